// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the LC-3 decode stage.
// Holds the opcode enumeration, the E_control field layout and its
// encodings, the writeback-select encodings and the datapath width.
package decode_pkg;

    // LC-3 instruction, IR and npc width (the ISA fixes this at 16)
    localparam int DATA_W_DEFAULT = 16;

    // All sixteen LC-3 primary opcodes, instruction bits [15:12]
    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_t;

    // E_control layout: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int E_W         = 6;
    localparam int E_ALU_HI    = 5;
    localparam int E_ALU_LO    = 4;
    localparam int E_PCSEL1_HI = 3;
    localparam int E_PCSEL1_LO = 2;
    localparam int E_PCSEL2    = 1;
    localparam int E_OP2SEL    = 0;

    // alu_control encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    // pcselect1 encodings: which offset field feeds the address adder
    localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

    // W_Control encodings: writeback source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_PC  = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    // Assemble an E_control word from its individual fields
    function automatic logic [E_W-1:0] pack_e(
        input logic [1:0] alu,
        input logic [1:0] pcsel1,
        input logic       pcsel2,
        input logic       op2sel
    );
        logic [E_W-1:0] e;
        e                          = '0;
        e[E_ALU_HI:E_ALU_LO]       = alu;
        e[E_PCSEL1_HI:E_PCSEL1_LO] = pcsel1;
        e[E_PCSEL2]                = pcsel2;
        e[E_OP2SEL]                = op2sel;
        return e;
    endfunction

endpackage

// File: rtl/decode_ctrl_lut.sv
// decode_ctrl_lut: purely combinational opcode decode for the LC-3
// decode stage. Maps an instruction word to the next E_control,
// W_Control and Mem_Control values plus an illegal-opcode flag.
// Unsupported opcodes (JSR, RTI, reserved 1101, TRAP) decode to all-zero
// controls so that a stray one behaves as a harmless no-op downstream.
module decode_ctrl_lut
    import decode_pkg::*;
(
    input  logic [DATA_W_DEFAULT-1:0] instr,
    output logic [E_W-1:0]            e_next,
    output logic [1:0]                w_next,
    output logic                      m_next,
    output logic                      illegal_next
);

    opcode_t opcode;
    logic    op2sel;
    logic    unused_instr_bits;

    assign opcode = opcode_t'(instr[15:12]);

    // Bit 5 selects immediate (1) or register (0) for ADD/AND; op2select
    // is the inverse so that 1 means "second operand from the register file"
    assign op2sel = ~instr[5];

    // Register numbers and offsets are consumed by later stages, not here
    assign unused_instr_bits = ^{instr[11:6], instr[4:0]};

    // Opcode lookup; pcselect fields are don't-care for ALU ops and held at 00
    always_comb begin
        e_next       = '0;
        w_next       = WB_ALU;
        m_next       = 1'b0;
        illegal_next = 1'b0;
        case (opcode)
            OP_ADD: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF11, 1'b0, op2sel);
            end
            OP_AND: begin
                e_next = pack_e(ALU_AND, PCSEL1_OFF11, 1'b0, op2sel);
            end
            OP_NOT: begin
                e_next = pack_e(ALU_NOT, PCSEL1_OFF11, 1'b0, 1'b0);
            end
            OP_BR, OP_ST: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
            end
            OP_LD: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                w_next = WB_MEM;
            end
            OP_LDI: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                w_next = WB_MEM;
                m_next = 1'b1;
            end
            OP_STI: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                m_next = 1'b1;
            end
            OP_LEA: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF9, 1'b1, 1'b0);
                w_next = WB_PC;
            end
            OP_LDR: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF6, 1'b0, 1'b0);
                w_next = WB_MEM;
            end
            OP_STR: begin
                e_next = pack_e(ALU_ADD, PCSEL1_OFF6, 1'b0, 1'b0);
            end
            OP_JMP: begin
                e_next = pack_e(ALU_ADD, PCSEL1_ZERO, 1'b0, 1'b0);
            end
            OP_JSR, OP_RTI, OP_RES, OP_TRAP: begin
                illegal_next = 1'b1;
            end
            default: begin
                illegal_next = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: LC-3 pipeline decode stage feeding the execute stage.
// Captures the fetched instruction and next-PC on enable_decode, registers
// the decoded execute/writeback/memory controls and an illegal-opcode flag,
// and produces decode_valid as enable_decode delayed by one clock.
// Optional feature (macro DECODE_FLUSH_EN): adds a flush input that
// replaces the captured instruction with a BR never-taken NOP (16'h0000),
// clears the controls and decode_valid, and keeps npc_out. Flush wins over
// a simultaneous enable_decode.
module decode_stage
    import decode_pkg::*;
#(
    parameter int              DATA_W    = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] RESET_NPC = 16'h3000
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] npc_in,
`ifdef DECODE_FLUSH_EN
    input  logic              flush,
`endif
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [E_W-1:0]    E_control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control,
    output logic              illegal_op,
    output logic              decode_valid
);

    logic [E_W-1:0] e_next;
    logic [1:0]     w_next;
    logic           m_next;
    logic           illegal_next;
    logic           flush_req;

`ifdef DECODE_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    decode_ctrl_lut u_lut (
        .instr        (dout),
        .e_next       (e_next),
        .w_next       (w_next),
        .m_next       (m_next),
        .illegal_next (illegal_next)
    );

    // Instruction and next-PC capture; a flush injects a NOP but keeps npc
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR      <= '0;
            npc_out <= RESET_NPC;
        end else if (flush_req) begin
            IR      <= '0;
        end else if (enable_decode) begin
            IR      <= dout;
            npc_out <= npc_in;
        end
    end

    // Decoded control registers, updated in the same edge as IR
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            E_control   <= '0;
            W_Control   <= WB_ALU;
            Mem_Control <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (flush_req) begin
            E_control   <= '0;
            W_Control   <= WB_ALU;
            Mem_Control <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (enable_decode) begin
            E_control   <= e_next;
            W_Control   <= w_next;
            Mem_Control <= m_next;
            illegal_op  <= illegal_next;
        end
    end

    // One-cycle-delayed capture strobe for the controller
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= enable_decode & ~flush_req;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage. A behavioural
// model of the stage is compared against the DUT every cycle, and directed
// vectors carry hand-computed literal expectations.
// Define DECODE_FLUSH_EN to also exercise the flush port.
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
`ifdef DECODE_FLUSH_EN
    logic        flush;
`endif
    logic [15:0] ir;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic        mem_control;
    logic        illegal_op;
    logic        decode_valid;

    int checks;
    int failures;
    bit checking;

    // model state
    logic [15:0] m_ir;
    logic [15:0] m_npc;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_mem;
    logic        m_ill;
    logic        m_valid;

    decode_stage dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
`ifdef DECODE_FLUSH_EN
        .flush         (flush),
`endif
        .IR            (ir),
        .npc_out       (npc_out),
        .E_control     (e_control),
        .W_Control     (w_control),
        .Mem_Control   (mem_control),
        .illegal_op    (illegal_op),
        .decode_valid  (decode_valid)
    );

    // free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // decoded controls from the instruction-set meaning of each opcode
    // returns {E_control[5:0], W_Control[1:0], Mem_Control, illegal}
    function automatic logic [9:0] expectCtrl(input logic [15:0] w);
        logic [3:0] op;
        logic [1:0] alu, pc1, wb;
        logic       pc2, op2, mem, ill;
        op  = w[15:12];
        alu = 2'd0; pc1 = 2'd0; wb = 2'd0;
        pc2 = 1'b0; op2 = 1'b0; mem = 1'b0; ill = 1'b0;
        case (op)
            4'h1: op2 = !w[5];
            4'h5: begin alu = 2'd1; op2 = !w[5]; end
            4'h9: alu = 2'd2;
            4'h0, 4'h2, 4'hA, 4'h3, 4'hB, 4'hE: begin pc1 = 2'd1; pc2 = 1'b1; end
            4'h6, 4'h7: pc1 = 2'd2;
            4'hC: pc1 = 2'd3;
            default: ill = 1'b1;
        endcase
        if (op == 4'h2 || op == 4'h6 || op == 4'hA) wb = 2'd2;
        if (op == 4'hE) wb = 2'd1;
        if (op == 4'hA || op == 4'hB) mem = 1'b1;
        return {alu, pc1, pc2, op2, wb, mem, ill};
    endfunction

    // behavioural model of the registered stage
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ir <= 16'h0000; m_npc <= 16'h3000;
            m_e <= 6'd0; m_w <= 2'd0; m_mem <= 1'b0; m_ill <= 1'b0;
            m_valid <= 1'b0;
        end else begin
`ifdef DECODE_FLUSH_EN
            if (flush) begin
                m_ir <= 16'h0000;
                m_e <= 6'd0; m_w <= 2'd0; m_mem <= 1'b0; m_ill <= 1'b0;
                m_valid <= 1'b0;
            end else
`endif
            begin
                m_valid <= enable_decode;
                if (enable_decode) begin
                    m_ir  <= dout;
                    m_npc <= npc_in;
                    {m_e, m_w, m_mem, m_ill} <= expectCtrl(dout);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // every-cycle comparison of DUT against the model
    always @(negedge clock) begin
        if (checking && !reset) begin
            checkOutput("model_ir", ir, m_ir);
            checkOutput("model_npc", npc_out, m_npc);
            checkOutput("model_e", {10'd0, e_control}, {10'd0, m_e});
            checkOutput("model_w", {14'd0, w_control}, {14'd0, m_w});
            checkOutput("model_mem", {15'd0, mem_control}, {15'd0, m_mem});
            checkOutput("model_ill", {15'd0, illegal_op}, {15'd0, m_ill});
            checkOutput("model_valid", {15'd0, decode_valid}, {15'd0, m_valid});
        end
    end

    // drive one cycle of inputs just after a falling edge, return after capture
    task automatic applyStimulus(input logic en, input logic [15:0] instr,
                                 input logic [15:0] npc);
        @(negedge clock);
        #1;
        enable_decode = en;
        dout          = instr;
        npc_in        = npc;
        @(posedge clock);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [15:0] x_ir,
                            input logic [15:0] x_npc, input logic [5:0] x_e,
                            input logic [1:0] x_w, input logic x_m,
                            input logic x_ill, input logic x_v);
        checkOutput({tag, "_ir"}, ir, x_ir);
        checkOutput({tag, "_npc"}, npc_out, x_npc);
        checkOutput({tag, "_e"}, {10'd0, e_control}, {10'd0, x_e});
        checkOutput({tag, "_w"}, {14'd0, w_control}, {14'd0, x_w});
        checkOutput({tag, "_mem"}, {15'd0, mem_control}, {15'd0, x_m});
        checkOutput({tag, "_ill"}, {15'd0, illegal_op}, {15'd0, x_ill});
        checkOutput({tag, "_valid"}, {15'd0, decode_valid}, {15'd0, x_v});
    endtask

    initial begin
        checks = 0; failures = 0; checking = 1'b0;
        reset = 1'b0; enable_decode = 1'b0; dout = 16'h0000; npc_in = 16'h0000;
`ifdef DECODE_FLUSH_EN
        flush = 1'b0;
`endif
        #3 reset = 1'b1;
        #2 checkAll("reset", 16'h0000, 16'h3000, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); @(negedge clock);
        #1 reset = 1'b0;
        checking = 1'b1;

        // ADD R1,R2,R3
        applyStimulus(1'b1, 16'h1283, 16'h3001);
        checkAll("add", 16'h1283, 16'h3001, 6'b000001, 2'd0, 1'b0, 1'b0, 1'b1);

        // reset asserted mid-cycle during a capture
        @(negedge clock);
        #1 enable_decode = 1'b1; dout = 16'h1283; npc_in = 16'h3005;
        #1 reset = 1'b1;
        #1 checkAll("midrst", 16'h0000, 16'h3000, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1 checkAll("rsthold", 16'h0000, 16'h3000, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // ADD again, then AND immediate followed by three idle cycles
        applyStimulus(1'b1, 16'h1283, 16'h3001);
        checkAll("add2", 16'h1283, 16'h3001, 6'b000001, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h52A5, 16'h3002);
        checkAll("and", 16'h52A5, 16'h3002, 6'b010000, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'hFFFF, 16'hBEEF);
            checkAll("andhold", 16'h52A5, 16'h3002, 6'b010000, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // loads
        applyStimulus(1'b1, 16'hA004, 16'h3003);
        checkAll("ldi", 16'hA004, 16'h3003, 6'b000110, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h6702, 16'h3004);
        checkAll("ldr", 16'h6702, 16'h3004, 6'b001000, 2'd2, 1'b0, 1'b0, 1'b1);

        // JMP, TRAP (illegal), then a legal ADD clears the flag
        applyStimulus(1'b1, 16'hC1C0, 16'h3005);
        checkAll("jmp", 16'hC1C0, 16'h3005, 6'b001100, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hF025, 16'h3006);
        checkAll("trap", 16'hF025, 16'h3006, 6'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h1283, 16'h3007);
        checkAll("clrill", 16'h1283, 16'h3007, 6'b000001, 2'd0, 1'b0, 1'b0, 1'b1);

        // further hand-computed opcodes: NOT, LEA, STI, ADD register form
        applyStimulus(1'b1, 16'h967F, 16'h3008);
        checkAll("not", 16'h967F, 16'h3008, 6'b100000, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hE20A, 16'h3009);
        checkAll("lea", 16'hE20A, 16'h3009, 6'b000110, 2'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hB601, 16'h300A);
        checkAll("sti", 16'hB601, 16'h300A, 6'b000110, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1025, 16'h300B);
        checkAll("addimm", 16'h1025, 16'h300B, 6'b000000, 2'd0, 1'b0, 1'b0, 1'b1);

        // sweep all opcodes with both bit-5 settings back to back (model checks)
        for (int op = 0; op < 16; op++) begin
            for (int b = 0; b < 2; b++) begin
                logic [3:0] opv;
                logic       bv;
                opv = op[3:0];
                bv  = b[0];
                applyStimulus(1'b1, {opv, 3'b101, 3'b010, bv, 5'b10011},
                              16'h4000 + 16'(op * 2 + b));
            end
        end

`ifdef DECODE_FLUSH_EN
        // flush together with enable: NOP injected, npc kept
        applyStimulus(1'b1, 16'h1283, 16'h3100);
        @(negedge clock);
        #1 flush = 1'b1; enable_decode = 1'b1; dout = 16'h6702; npc_in = 16'h3101;
        @(posedge clock);
        #1 checkAll("flush", 16'h0000, 16'h3100, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hF025, 16'h3102);
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        checkAll("postflush", 16'h0000, 16'h3100, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
`endif

        applyStimulus(1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        @(negedge clock);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- LC-3 pipeline decode stage, directly upstream of the execute stage.
- Captures the fetched instruction word and next-PC when enabled.
- Generates registered IR, npc_out, E_control, W_Control, Mem_Control, which drive the execute stage's IR, npc_in, E_control, W_Control_in and Mem_Control_in inputs.
- Flags unsupported opcodes and provides a one-cycle-delayed valid strobe for the controller.

Parameters:
- DATA_W, 16, width of instruction, IR and npc paths (LC-3 fixed; other values unsupported).
- RESET_NPC, 16'h3000, npc_out value after reset.

Ports:
- clock  input  1  stage clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable_decode  input  1  capture strobe from controller.
- dout  input  DATA_W  instruction word from fetch/instruction memory.
- npc_in  input  DATA_W  PC+1 from fetch.
- IR  output  DATA_W  registered instruction.
- npc_out  output  DATA_W  registered npc_in.
- E_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  writeback select: 0 = ALU, 1 = PC (LEA), 2 = memory.
- Mem_Control  output  1  1 = indirect access (LDI/STI).
- illegal_op  output  1  registered flag for an unsupported opcode.
- decode_valid  output  1  enable_decode delayed by one clock.

Behaviour:
- Reset (asynchronous, immediate, including mid-capture):
  - IR = 0, npc_out = RESET_NPC.
  - E_control = 0, W_Control = 0, Mem_Control = 0, illegal_op = 0, decode_valid = 0.
- Capture:
  - On a rising edge with enable_decode = 1: IR <= dout, npc_out <= npc_in, and all control outputs update from dout[15:12] in the same edge.
  - Latency is one clock from dout to every output.
- Hold: with enable_decode = 0, all outputs except decode_valid hold their values indefinitely.
- decode_valid <= enable_decode every cycle. Back-to-back enables give a continuous high.
- E_control per opcode (op2select = ~dout[5] for ADD/AND):
  - ADD(0001): 00_00_0_op2.
  - AND(0101): 01_00_0_op2.
  - NOT(1001): 100000.
  - BR(0000), LD(0010), LDI(1010), ST(0011), STI(1011), LEA(1110): 000110.
  - LDR(0110), STR(0111): 001000.
  - JMP(1100): 001100.
- W_Control per opcode:
  - 2 for LD/LDR/LDI.
  - 1 for LEA.
  - 0 for all others.
- Mem_Control per opcode: 1 for LDI/STI, 0 for all others.
- Illegal opcodes (0100 JSR, 1000 RTI, 1101, 1111 TRAP):
  - E_control/W_Control/Mem_Control = 0 and illegal_op = 1.
  - IR/npc_out are still captured.
  - The next legal capture clears illegal_op.
- No internal state machine beyond the output registers. The decode table is purely a function of the captured word.

Optional Feature:
- Macro: DECODE_FLUSH_EN.
- With it defined:
  - Adds input port flush (1 bit).
  - On a rising edge with flush = 1: IR <= 16'h0000 (BR never-taken NOP), E_control/W_Control/Mem_Control/illegal_op <= 0, decode_valid <= 0; npc_out holds.
  - flush has priority over a simultaneous enable_decode.
- Without it: no flush port; behaviour exactly as above.

Decomposition:
- decode_pkg holds:
  - opcode enum (4-bit, all 16 codes named);
  - localparams for E_control field positions and pcselect1 encodings (00 off11, 01 off9, 10 off6, 11 zero);
  - W_Control encodings (WB_ALU, WB_PC, WB_MEM);
  - DATA_W default.
- One combinational sub-module, decode_ctrl_lut:
  - input: instruction word;
  - outputs: next E_control, W_Control, Mem_Control, illegal.
  - The top level holds only the registers, enable/flush priority and reset.

Test Plan:
- Reset asserted mid-cycle with enable_decode = 1, dout = 16'h1283 → outputs immediately IR = 0, npc_out = 16'h3000, E_control = 0, decode_valid = 0.
- ADD R1,R2,R3 (dout = 16'h1283, npc_in = 16'h3001, enable = 1) → next edge: IR = 1283, npc_out = 3001, E_control = 6'b000001, W = 0, Mem = 0, decode_valid = 1.
- AND R1,R2,#5 (16'h52A5) then enable = 0 for 3 cycles → E_control = 6'b010000 held for 3 cycles; decode_valid = 1 then 0.
- LDI R0,#4 (16'hA004) → E_control = 000110, W = 2, Mem = 1. LDR R3,R4,#2 (16'h6702) → E_control = 001000, W = 2, Mem = 0.
- JMP R7 (16'hC1C0) → E_control = 001100. Then TRAP (16'hF025) → controls 0, illegal_op = 1, IR = F025. Then ADD 16'h1283 → illegal_op = 0.
- With DECODE_FLUSH_EN: flush = 1 together with enable = 1, dout = 16'h6702 → IR = 0, controls 0, decode_valid = 0, npc_out unchanged.
